// File: rtl/axi_wdata_master_pkg.sv
// Shared AXI definitions for the write-data master: field widths, burst and state encodings,
// and the command legality rule.
package axi_wdata_master_pkg;

   localparam int AXI_LEN_W   = 8;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;

   typedef enum logic [AXI_BURST_W-1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BURST = 2'b01,
      DRAIN = 2'b10
   } state_t;

   // WRAP bursts only support 2, 4, 8 or 16 beats; a beat may not be wider than the bus.
   function automatic logic cmd_legal(input logic [AXI_LEN_W-1:0]   len,
                                      input logic [AXI_SIZE_W-1:0]  size,
                                      input logic [AXI_BURST_W-1:0] burst,
                                      input int                     strb_w);
      logic ok;
      ok = ((32'd1 << size) <= 32'(strb_w));
      if (burst == BURST_RSVD) ok = 1'b0;
      if ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/axi_lane_calc.sv
// Combinational byte-lane helper: strobe for the current lane address and the lane address
// of the following beat. Shared with the read-side aligner.
module axi_lane_calc
   import axi_wdata_master_pkg::*;
#(
   parameter  int STRB_W = 4,
   localparam int LANE_W = $clog2(STRB_W)
) (
   input  logic [LANE_W-1:0]      addr,
   input  logic [AXI_SIZE_W-1:0]  size,
   input  logic [AXI_BURST_W-1:0] burst,
   input  logic [AXI_LEN_W-1:0]   len,
   output logic [LANE_W-1:0]      next_addr,
   output logic [STRB_W-1:0]      strb
);

   localparam int CW = 16;

   logic [CW-1:0] nbytes;
   logic [CW-1:0] addr_w;
   logic [CW-1:0] aligned;
   logic [CW-1:0] incr;
   logic [CW-1:0] wrap_bytes;
   logic [CW-1:0] wrap_mask;

   always_comb begin
      nbytes     = CW'(1) << size;
      addr_w     = CW'(addr);
      aligned    = addr_w & ~(nbytes - CW'(1));
      incr       = aligned + nbytes;
      // A wrap window wider than the bus masks every lane bit, which degenerates to INCR.
      wrap_bytes = (CW'(len) + CW'(1)) << size;
      wrap_mask  = wrap_bytes - CW'(1);

      strb = '0;
      for (int i = 0; i < STRB_W; i++) begin
         strb[i] = (CW'(i) >= addr_w) && (CW'(i) < incr);
      end

      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = LANE_W'((addr_w & ~wrap_mask) | (incr & wrap_mask));
         default:     next_addr = LANE_W'(incr);
      endcase
   end

endmodule

// File: rtl/axi_wdata_master.sv
// AXI write-data channel master: takes a burst command and a stream of right-justified
// payload beats, and emits lane-aligned WDATA/WSTRB/WLAST with a single output register.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// BURST | accepting payload beats until the beat counter reaches len
// DRAIN | last beat loaded, waiting for its W handshake
module axi_wdata_master
   import axi_wdata_master_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int STRB_W = DATA_W / 8,
   localparam int LANE_W = $clog2(STRB_W)
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [AXI_LEN_W-1:0]   cmd_len,
   input  logic [AXI_SIZE_W-1:0]  cmd_size,
   input  logic [AXI_BURST_W-1:0] cmd_burst,
   input  logic [LANE_W-1:0]      cmd_addr,
   input  logic                   src_valid,
   output logic                   src_ready,
   input  logic [DATA_W-1:0]      src_data,
   output logic [DATA_W-1:0]      wdata,
   output logic [STRB_W-1:0]      wstrb,
   output logic                   wlast,
   output logic                   wvalid,
   input  logic                   wready,
   output logic                   done,
   output logic                   err
);

   state_t                 state, state_nxt;
   logic [AXI_LEN_W-1:0]   len_q;
   logic [AXI_SIZE_W-1:0]  size_q;
   logic [AXI_BURST_W-1:0] burst_q;
   logic [LANE_W-1:0]      addr_q;
   logic [AXI_LEN_W-1:0]   cnt_q;

   logic                   cmd_fire, cmd_ok, src_fire, w_fire, last_beat;
   logic [LANE_W-1:0]      next_addr, align_mask, aligned;
   logic [STRB_W-1:0]      lane_strb;
   logic [DATA_W-1:0]      shifted, data_nxt;

   assign cmd_ready = (state == IDLE);
   assign src_ready = (state == BURST) && (!wvalid || wready);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign cmd_ok    = cmd_legal(cmd_len, cmd_size, cmd_burst, STRB_W);
   assign src_fire  = src_valid && src_ready;
   assign w_fire    = wvalid && wready;
   assign last_beat = (cnt_q == len_q);

   axi_lane_calc #(.STRB_W(STRB_W)) u_lane_calc (
      .addr      (addr_q),
      .size      (size_q),
      .burst     (burst_q),
      .len       (len_q),
      .next_addr (next_addr),
      .strb      (lane_strb)
   );

   always_comb begin
      align_mask = LANE_W'((16'd1 << size_q) - 16'd1);
      aligned    = addr_q & ~align_mask;
      shifted    = src_data << {aligned, 3'b000};
      data_nxt   = '0;
      for (int i = 0; i < STRB_W; i++) begin
         data_nxt[8*i +: 8] = lane_strb[i] ? shifted[8*i +: 8] : 8'h00;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_fire && cmd_ok)   state_nxt = BURST;
         BURST:   if (src_fire && last_beat) state_nxt = DRAIN;
         DRAIN:   if (w_fire && wlast)      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state   <= IDLE;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         wdata   <= '0;
         wstrb   <= '0;
         wlast   <= 1'b0;
         wvalid  <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state == DRAIN) && w_fire && wlast;
         err   <= cmd_fire && !cmd_ok;

         if (cmd_fire) begin
            len_q   <= cmd_len;
            size_q  <= cmd_size;
            burst_q <= cmd_burst;
            addr_q  <= cmd_addr;
            cnt_q   <= '0;
         end

         if (src_fire) begin
            wdata  <= data_nxt;
            wstrb  <= lane_strb;
            wlast  <= last_beat;
            wvalid <= 1'b1;
            addr_q <= next_addr;
            if (!last_beat) cnt_q <= cnt_q + 8'd1;
         end else if (w_fire) begin
            wvalid <= 1'b0;
            wlast  <= 1'b0;
         end
      end
   end

endmodule

// File: doc/axi_wdata_master.md
AXI_WDATA_MASTER -- requirements
Module: axi_wdata_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32, W data width in bits; legal values 32, 64, 128.
REQ-002 SHALL have derived constant STRB_W = DATA_W/8 and LANE_W = log2(STRB_W), not overridable.
REQ-003 SHALL use one clock and a synchronous active-low reset. The ports are `aclk` and `aresetn`, listed first.
REQ-004 Ports (name, direction, width, meaning):
- aclk, in, 1: clock, all logic on rising edge.
- aresetn, in, 1: synchronous active-low reset.
- cmd_valid, in, 1: burst command valid.
- cmd_ready, out, 1: command accepted when cmd_valid and cmd_ready are both high.
- cmd_len, in, 8: AXI AWLEN; beats = cmd_len+1.
- cmd_size, in, 3: AXI AWSIZE; bytes per beat = 2^cmd_size.
- cmd_burst, in, 2: 00 FIXED, 01 INCR, 10 WRAP.
- cmd_addr, in, LANE_W: low bits of the start address.
- src_valid, in, 1: payload beat valid.
- src_ready, out, 1: payload beat accepted.
- src_data, in, DATA_W: payload, narrow data right-justified.
- wdata, out, DATA_W: AXI WDATA.
- wstrb, out, STRB_W: AXI WSTRB.
- wlast, out, 1: AXI WLAST.
- wvalid, out, 1: AXI WVALID.
- wready, in, 1: AXI WREADY.
- done, out, 1: one-cycle pulse at burst completion.
- err, out, 1: one-cycle pulse when a command is rejected.

Function
REQ-005 SHALL implement a state machine with states IDLE, BURST and DRAIN.
REQ-006 cmd_ready SHALL equal (state==IDLE). On acceptance, cmd_len, cmd_size, cmd_burst and cmd_addr are registered.
REQ-007 A command is illegal if 2^cmd_size > STRB_W, or cmd_burst==11, or cmd_burst==WRAP with cmd_len not in {1,3,7,15}. An illegal command SHALL:
- pulse err the cycle after acceptance;
- stay in IDLE;
- generate no beats.
REQ-008 A legal command SHALL move the state to BURST and clear the beat counter to 0.
REQ-009 src_ready SHALL equal (state==BURST) && (!wvalid || wready). This is a single output register with no bubble under continuous flow.
REQ-010 A source handshake in cycle N SHALL load wdata, wstrb and wlast, and assert wvalid in cycle N+1.
REQ-011 While wvalid is high and wready is low, wdata, wstrb, wlast and wvalid SHALL hold stable.
REQ-012 A W handshake with no new source beat in the same cycle SHALL deassert wvalid next cycle.
REQ-013 Per-beat lane address:
- beat 0 uses cmd_addr;
- FIXED reuses cmd_addr on every beat;
- INCR adds 2^size to the size-aligned address, mod STRB_W;
- WRAP increments as INCR but wraps within the (len+1)*2^size byte boundary, computed on the low LANE_W bits.
REQ-014 wdata SHALL be src_data shifted left by 8*(lane address aligned down to 2^size); bytes outside the strobe SHALL be driven 0.
REQ-015 wstrb SHALL set bits from the lane address up to the end of the 2^size-aligned chunk. Example for DATA_W=32: an unaligned INCR first beat at address 2 with size 2 gives wstrb=1100.
REQ-016 wlast SHALL be 1 only on the beat whose counter equals the registered len. That source handshake SHALL move the state BURST->DRAIN.
REQ-017 In DRAIN, the W handshake with wlast=1 SHALL:
- return the state to IDLE next cycle;
- pulse done in that same cycle.
A command may be accepted in the cycle done is high.
REQ-018 For len=0, the first beat SHALL carry wlast=1.
REQ-019 The beat counter SHALL be 8 bits wide and SHALL never exceed len. There is no wrap past 255.

Reset
REQ-020 While aresetn is low at a clock edge, the block SHALL set:
- state=IDLE;
- wvalid=0, wlast=0, wdata=0, wstrb=0;
- done=0, err=0;
- counter=0.
REQ-021 A reset during BURST or DRAIN SHALL abandon the burst. No done pulse follows, and cmd_ready=1 on the first cycle after reset is released.

Structure
REQ-022 The burst-type encodings (FIXED, INCR, WRAP) and the state encodings SHALL live in the shared AXI package, together with the AXI field widths for len, size and burst.
REQ-023 The lane-address and strobe computation SHALL be a combinational sub-module, axi_lane_calc, with inputs addr, size, burst and len and outputs next_addr and strb. It is reused by the read-side aligner.

Verification
REQ-024 INCR, DATA_W=32, len=3, size=2, addr=0, src 0x11111111..0x44444444, wready=1. Required response:
- 4 consecutive beats, wstrb=F;
- wlast on beat 4;
- done in the cycle after beat 4.
REQ-025 INCR, size=0, addr=1, len=3, src low bytes AA, BB, CC, DD. Required response:
- wdata 0x0000AA00 with wstrb 2;
- 0x00BB0000 with wstrb 4;
- 0xCC000000 with wstrb 8;
- 0x000000DD with wstrb 1.
REQ-026 WRAP, size=0, len=1, addr=3. Required response: wstrb 8 then wstrb 4. Same stimulus with FIXED gives wstrb 8 on both beats.
REQ-027 wready held low for 3 cycles on beat 2 of a 4-beat burst. Required response: wdata and wstrb stable, src_ready=0 during the stall, all 4 beats delivered in order.
REQ-028 cmd_size=3 on DATA_W=32. Required response: err pulses once, wvalid stays 0, a following legal command completes normally.
REQ-029 aresetn low for 1 cycle during beat 2 of len=7. Required response: all outputs return to reset values, no done pulse, a new len=0 command gives a single beat with wlast=1.
